// File: rtl/display_hdmi_line_sched.sv
// display_hdmi_line_sched: ping-pong line-buffer controller for the HDMI path.
// Steers packed input words into the free line-RAM bank, records the length
// of each completed line, and sequences reads of the oldest line on request.
// Optional feature macro: DISPLAY_HDMI_LINE_SCHED_FILL_EN (blank-fill on underrun).
module display_hdmi_line_sched #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  in_pclk,
    input  logic                  in_rstn,
    input  logic                  in_vs,
    input  logic                  in_de,
    input  logic                  in_valid,
    input  logic                  in_rd_req,
    input  logic                  in_flag_clr,
    output logic                  out_we,
    output logic [ADDR_WIDTH:0]   out_waddr,
    output logic                  out_re,
    output logic [ADDR_WIDTH:0]   out_raddr,
    output logic                  out_rd_last,
    output logic                  out_fill,
    output logic [ADDR_WIDTH-1:0] out_line_y,
    output logic                  out_overrun,
    output logic                  out_underrun
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RELEASE
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
        , S_FILL
`endif
    } state_t;

    state_t        state;
    logic          wbank, rbank, de_1p, vs_1p, line_acc;
    logic [1:0]    full, full_nxt;
    logic [CW-1:0] wcnt, rcnt, len0, len1, rlen;
    logic          vs_rise, line_start, line_end, accept;
    logic          wr_ok, wr_drop, drop_line, commit, rel_now;
    logic          ovr_set, unr_set;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
    logic [CW-1:0] lenlast;
    logic          fill_q;
    assign out_fill = fill_q;
`else
    assign out_fill = 1'b0;
`endif

    assign vs_rise    = in_vs & ~vs_1p;
    assign line_start = in_de & ~de_1p;
    assign line_end   = ~in_de & de_1p;
    // A line is judged once, at its first de cycle; later cycles reuse that verdict.
    assign accept     = line_start ? ~full[wbank] : line_acc;
    assign wr_ok      = in_de & in_valid & accept & ~wcnt[ADDR_WIDTH];
    assign wr_drop    = in_de & in_valid & accept & wcnt[ADDR_WIDTH];
    assign drop_line  = line_start & full[wbank];
    assign commit     = line_end & line_acc & (wcnt != '0);
    assign rel_now    = (state == S_RELEASE);
    assign rlen       = rbank ? len1 : len0;
    assign ovr_set    = ~vs_rise & (drop_line | wr_drop);
    assign unr_set    = ~vs_rise & in_rd_req & ((state != S_IDLE) | ~full[rbank]);

    // Bank occupancy: a commit and a release may land together, always on different banks.
    always_comb begin
        // NOTE: default assignment first so no path leaves full_nxt unassigned (no latch).
        full_nxt = full;
        if (commit)  full_nxt[wbank] = 1'b1;
        if (rel_now) full_nxt[rbank] = 1'b0;
    end

    // Write steering, read sequencing, sticky flags and frame flush.
    always_ff @(posedge in_pclk) begin
        if (!in_rstn) begin
            state        <= S_IDLE;
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            de_1p        <= 1'b0;
            vs_1p        <= 1'b0;
            line_acc     <= 1'b0;
            full         <= 2'b00;
            wcnt         <= '0;
            rcnt         <= '0;
            len0         <= '0;
            len1         <= '0;
            out_we       <= 1'b0;
            out_waddr    <= '0;
            out_re       <= 1'b0;
            out_raddr    <= '0;
            out_rd_last  <= 1'b0;
            out_line_y   <= '0;
            out_overrun  <= 1'b0;
            out_underrun <= 1'b0;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
            lenlast      <= '0;
            fill_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here so every branch sees start-of-cycle state.
            de_1p        <= in_de;
            vs_1p        <= in_vs;
            out_overrun  <= ovr_set | (out_overrun & ~in_flag_clr);
            out_underrun <= unr_set | (out_underrun & ~in_flag_clr);
            out_we       <= 1'b0;
            out_re       <= 1'b0;
            out_rd_last  <= 1'b0;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
            fill_q       <= 1'b0;
`endif
            if (vs_rise) begin
                // Frame flush outranks every other event in this cycle.
                state      <= S_IDLE;
                full       <= 2'b00;
                wbank      <= 1'b0;
                rbank      <= 1'b0;
                wcnt       <= '0;
                rcnt       <= '0;
                line_acc   <= 1'b0;
                out_line_y <= '0;
            end else begin
                full <= full_nxt;
                if (line_start) line_acc <= ~full[wbank];
                out_we <= wr_ok;
                if (wr_ok) begin
                    out_waddr <= {wbank, wcnt[ADDR_WIDTH-1:0]};
                    wcnt      <= wcnt + 1'b1;
                end
                if (commit) begin
                    if (wbank) len1 <= wcnt;
                    else       len0 <= wcnt;
                    wbank <= ~wbank;
                    wcnt  <= '0;
                end

                case (state)
                    S_IDLE: begin
                        if (in_rd_req) begin
                            if (full[rbank]) begin
                                state       <= S_READ;
                                out_re      <= 1'b1;
                                out_raddr   <= {rbank, {ADDR_WIDTH{1'b0}}};
                                out_rd_last <= (rlen == CW'(1));
                                rcnt        <= CW'(1);
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
                            end else if (lenlast != '0) begin
                                state       <= S_FILL;
                                fill_q      <= 1'b1;
                                out_rd_last <= (lenlast == CW'(1));
                                rcnt        <= CW'(1);
`endif
                            end
                        end
                    end
                    S_READ: begin
                        if (out_rd_last) begin
                            state <= S_RELEASE;
                        end else begin
                            out_re      <= 1'b1;
                            out_raddr   <= {rbank, rcnt[ADDR_WIDTH-1:0]};
                            out_rd_last <= (rcnt == rlen - CW'(1));
                            rcnt        <= rcnt + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        rbank      <= ~rbank;
                        out_line_y <= out_line_y + 1'b1;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
                        lenlast    <= rlen;
`endif
                        state      <= S_IDLE;
                    end
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
                    S_FILL: begin
                        if (out_rd_last) begin
                            state <= S_IDLE;
                        end else begin
                            fill_q      <= 1'b1;
                            out_rd_last <= (rcnt == lenlast - CW'(1));
                            rcnt        <= rcnt + 1'b1;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_hdmi_line_sched.sv
// tb_display_hdmi_line_sched: randomized self-checking bench. The reference
// model is a queue of completed line lengths plus bank/line counters.
module tb_display_hdmi_line_sched;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          in_pclk = 1'b0;
    logic          in_rstn, in_vs, in_de, in_valid, in_rd_req, in_flag_clr;
    logic          out_we, out_re, out_rd_last, out_fill, out_overrun, out_underrun;
    logic [AW:0]   out_waddr, out_raddr;
    logic [AW-1:0] out_line_y;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int lens[$];
    bit wb, rb;
    int y;
    bit exp_ovr, exp_unr;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
    int lenlast;
`endif

    display_hdmi_line_sched #(.ADDR_WIDTH(AW)) dut (
        .in_pclk     (in_pclk),
        .in_rstn     (in_rstn),
        .in_vs       (in_vs),
        .in_de       (in_de),
        .in_valid    (in_valid),
        .in_rd_req   (in_rd_req),
        .in_flag_clr (in_flag_clr),
        .out_we      (out_we),
        .out_waddr   (out_waddr),
        .out_re      (out_re),
        .out_raddr   (out_raddr),
        .out_rd_last (out_rd_last),
        .out_fill    (out_fill),
        .out_line_y  (out_line_y),
        .out_overrun (out_overrun),
        .out_underrun(out_underrun)
    );

    always #5 in_pclk = ~in_pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        lens.delete();
        wb = 0; rb = 0; y = 0; exp_ovr = 0; exp_unr = 0;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
        lenlast = 0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, out_we, 0);
        check({tag, "_waddr"}, out_waddr, 0);
        check({tag, "_re"}, out_re, 0);
        check({tag, "_raddr"}, out_raddr, 0);
        check({tag, "_rd_last"}, out_rd_last, 0);
        check({tag, "_fill"}, out_fill, 0);
        check({tag, "_line_y"}, out_line_y, 0);
        check({tag, "_ovr"}, out_overrun, 0);
        check({tag, "_unr"}, out_underrun, 0);
    endtask

    task automatic check_we(input bit pw, input int pa);
        check("we", out_we, pw);
        if (pw) check("waddr", out_waddr, pa);
    endtask

    task automatic check_flags();
        check("ovr_flag", out_overrun, exp_ovr);
        check("unr_flag", out_underrun, exp_unr);
    endtask

    // One input line of n words with random valid gaps; checks each write one cycle later.
    task automatic send_line(input int n, input int gap);
        bit acc;
        bit pw;
        int pa;
        int words;
        acc = (lens.size() < 2);
        words = 0; pw = 0; pa = 0;
        do begin
            @(negedge in_pclk);
            check_we(pw, pa);
            in_de    = 1'b1;
            in_valid = (n > 0) && ($urandom_range(0, 99) >= gap);
            pw = in_valid && acc && (words < DEPTH);
            pa = int'(wb) * DEPTH + (words % DEPTH);
            if (in_valid) words++;
        end while (words < n);
        @(negedge in_pclk);
        check_we(pw, pa);
        in_de = 1'b0; in_valid = 1'b0;
        @(negedge in_pclk);
        check_we(0, 0);
        if (acc && words > 0) begin
            lens.push_back(words > DEPTH ? DEPTH : words);
            wb = ~wb;
        end
        if (!acc || words > DEPTH) exp_ovr = 1;
        check("overrun_after_line", out_overrun, exp_ovr);
    endtask

    // Request the next line; optionally poke a second request or a frame sync mid-read.
    task automatic request(input int poke_at, input int vs_at);
        int len;
        @(negedge in_pclk); in_rd_req = 1'b1;
        @(negedge in_pclk); in_rd_req = 1'b0;
        if (lens.size() > 0) begin
            len = lens.pop_front();
            for (int i = 0; i < len; i++) begin
                check("re", out_re, 1);
                check("raddr", out_raddr, int'(rb) * DEPTH + i);
                check("rd_last", out_rd_last, i == len - 1);
                in_rd_req = (i == poke_at);
                in_vs     = (i == vs_at);
                if (i == poke_at) exp_unr = 1;
                if (i == vs_at) begin
                    @(negedge in_pclk);
                    in_vs = 1'b0;
                    lens.delete(); wb = 0; rb = 0; y = 0;
                    check("flush_re", out_re, 0);
                    check("flush_rd_last", out_rd_last, 0);
                    check("flush_line_y", out_line_y, 0);
                    return;
                end
                @(negedge in_pclk);
            end
            in_rd_req = 1'b0;
            check("re_end", out_re, 0);
            @(negedge in_pclk);
            y++; rb = ~rb;
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
            lenlast = len;
`endif
            check("line_y", out_line_y, y);
        end else begin
            exp_unr = 1;
            check("underrun", out_underrun, 1);
`ifdef DISPLAY_HDMI_LINE_SCHED_FILL_EN
            for (int i = 0; i < lenlast; i++) begin
                check("fill", out_fill, 1);
                check("fill_re", out_re, 0);
                check("fill_last", out_rd_last, i == lenlast - 1);
                @(negedge in_pclk);
            end
`endif
            check("unr_re", out_re, 0);
            check("unr_fill", out_fill, 0);
            @(negedge in_pclk);
            check("unr_re2", out_re, 0);
            check("unr_line_y", out_line_y, y);
        end
    endtask

    task automatic clear_flags();
        @(negedge in_pclk); in_flag_clr = 1'b1;
        @(negedge in_pclk); in_flag_clr = 1'b0;
        exp_ovr = 0; exp_unr = 0;
        check_flags();
    endtask

    task automatic frame_sync();
        @(negedge in_pclk); in_vs = 1'b1;
        @(negedge in_pclk); in_vs = 1'b0;
        lens.delete(); wb = 0; rb = 0; y = 0;
        check("vs_line_y", out_line_y, 0);
    endtask

    initial begin
        in_rstn = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_valid = 1'b0;
        in_rd_req = 1'b0; in_flag_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge in_pclk);
        check_all_zero("reset");
        in_rstn = 1'b1;

        // Basic line
        send_line(8, 0);
        request(-1, -1);
        check_flags();

        // Ping-pong
        send_line(16, 0);
        send_line(16, 0);
        request(-1, -1);
        request(-1, -1);
        check_flags();

        // Overrun: third line dropped, first request returns the first line
        send_line(5, 20);
        send_line(7, 20);
        send_line(9, 20);
        request(-1, -1);
        request(-1, -1);
        check_flags();
        request(-1, -1);
        check_flags();
        clear_flags();

        // Request during a read is ignored and flagged
        send_line(6, 0);
        request(2, -1);
        check_flags();
        clear_flags();

        // Flush during READ at rcnt=3
        frame_sync();
        send_line(10, 0);
        send_line(4, 0);
        request(-1, 3);
        send_line(5, 0);
        request(-1, -1);
        request(-1, -1);
        check_flags();
        clear_flags();

        // Saturation at a full bank's worth of words
        send_line(DEPTH + 2, 0);
        request(-1, -1);
        check_flags();
        clear_flags();

        // Empty de pulse is ignored
        send_line(0, 0);
        request(-1, -1);
        check_flags();
        clear_flags();

        // Randomized mix
        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5)
                send_line(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24), $urandom_range(0, 50));
            else if (op < 9)
                request(-1, -1);
            else
                clear_flags();
            check_flags();
        end

        // Reset mid-write
        @(negedge in_pclk); in_de = 1'b1; in_valid = 1'b1;
        repeat (3) @(negedge in_pclk);
        in_rstn = 1'b0; in_de = 1'b0; in_valid = 1'b0;
        @(negedge in_pclk);
        check_all_zero("midreset");
        in_rstn = 1'b1;
        model_reset();
        send_line(3, 0);
        request(-1, -1);
        check_flags();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_hdmi_line_sched.md
# display_hdmi_line_sched

Ping-pong line-buffer controller for the HDMI display path. It sits between the packed-pixel input stream and the two-bank line RAM feeding the pixel unpacker. It steers incoming packed words into the free bank and records each completed line's word count. On request from the output timing generator, it sequences reads of the oldest completed line and flags overrun and underrun.

## Interface
- ADDR_WIDTH, 10, word-address width of one bank; a line holds at most 2^ADDR_WIDTH packed words
- in_pclk  in  1  pixel clock; only clock
- in_rstn  in  1  reset, synchronous, active-low
- in_vs  in  1  frame sync; a rising edge starts a new frame
- in_de  in  1  input line active
- in_valid  in  1  packed word present (qualified by in_de)
- in_rd_req  in  1  one-cycle pulse: output timing wants the next line
- in_flag_clr  in  1  clears the sticky flags
- out_we  out  1  line RAM write enable
- out_waddr  out  ADDR_WIDTH+1  {bank, word index}
- out_re  out  1  line RAM read enable
- out_raddr  out  ADDR_WIDTH+1  {bank, word index}
- out_rd_last  out  1  last word of the current read or fill
- out_fill  out  1  blank-fill cycle (macro only; tied to 0 otherwise)
- out_line_y  out  ADDR_WIDTH  lines released this frame
- out_overrun  out  1  sticky: an input line was dropped
- out_underrun  out  1  sticky: a request was not served with data

## Operation
- State: wbank, wcnt (ADDR_WIDTH+1 bits), full[1:0], len0, len1, rbank, rcnt, de_1P, vs_1P.
- Read FSM states: IDLE, READ, RELEASE, FILL (FILL only with the macro).
- **Line start** (in_de=1, de_1P=0):
  - If full[wbank]=1, the whole line is dropped: no out_we, out_overrun←1.
  - Otherwise the line is accepted.
- **Write:** for an accepted line, each in_valid&in_de produces out_we=1 with out_waddr={wbank,wcnt[ADDR_WIDTH-1:0]}, then wcnt++.
  - wcnt saturates at 2^ADDR_WIDTH.
  - Further words are discarded and set out_overrun.
- **Line end** (in_de=0, de_1P=1, line accepted, wcnt>0):
  - full[wbank]←1, len[wbank]←wcnt, wbank toggles, wcnt←0.
  - An accepted line with wcnt=0 is ignored.
- **IDLE + in_rd_req:**
  - If full[rbank]=1 → READ with rcnt←0.
  - Otherwise out_underrun←1 and the FSM goes to FILL (macro) or stays in IDLE.
- **READ:** out_re=1, out_raddr={rbank,rcnt}, rcnt++.
  - out_rd_last=1 when rcnt=len[rbank]-1; the next state is RELEASE.
- **RELEASE:** full[rbank]←0, rbank toggles, out_line_y++, lenlast←len[rbank], → IDLE.
- **in_rd_req outside IDLE:** ignored, and out_underrun←1.
- **in_vs rising edge:**
  - Clears full, wbank, rbank, wcnt, out_line_y; the FSM goes to IDLE.
  - Any in-flight read or fill is aborted with out_re/out_fill forced 0 from the next cycle.
  - The sticky flags are not cleared.
  - This flush has priority over every other same-cycle event.
- **Same-cycle line-end and RELEASE:** both apply. They always act on different banks, because writes only target a non-full bank.
- **in_flag_clr:** clears both sticky flags. A set condition in the same cycle wins.

## Timing
- Reset: every output 0, FSM in IDLE, full=00, wbank=rbank=0, lenlast=0.
- Write path is registered: in_valid at cycle t → out_we at t+1.
- Read path: in_rd_req at t → out_re high for cycles t+1 … t+len.
  - out_rd_last at t+len.
  - RELEASE at t+len+1.
  - The earliest next accepted request is at t+len+2.
- Overrun is set at t+1 after the offending line start. Underrun is set at t+1 after the request.
- out_line_y updates at the RELEASE cycle +1.
- The unpacker's fixed RAM read latency is applied downstream. This block issues addresses only.

## Configuration
- **DISPLAY_HDMI_LINE_SCHED_FILL_EN defined:**
  - An underrun request with lenlast>0 enters FILL.
  - FILL asserts out_fill=1 (out_re=0) for lenlast cycles; out_rd_last is asserted on the final one.
  - The FSM then returns to IDLE with no bank, flag or line_y change.
  - If lenlast=0, the FSM stays in IDLE.
- **Undefined:** the FILL state is absent, out_fill is tied to 0, and an underrun leaves the FSM in IDLE.

## Test plan
- **Basic line:** reset, then one 8-word line into bank 0, then in_rd_req. Expect:
  - out_waddr 0…7
  - out_re for 8 cycles with out_raddr 0…7
  - out_rd_last on raddr 7
  - out_line_y=1, full=00
- **Ping-pong:** two back-to-back 16-word lines. Expect:
  - second line written at waddr 1024…1039 (ADDR_WIDTH=10)
  - two requests read bank 0 then bank 1
- **Overrun:** three lines with no request. Expect:
  - third line produces no out_we
  - out_overrun=1
  - the first request returns line 1 data
- **Underrun:** request with empty buffers. Expect:
  - out_underrun=1
  - out_re never asserted
  - with FILL_EN and a prior 8-word line: out_fill for 8 cycles
- **Flush:** in_vs rising edge during a READ at rcnt=3. Expect:
  - out_re low on the next cycle
  - full=00, out_line_y=0
  - next line written to bank 0
- **Reset mid-operation:** in_rstn low for 1 cycle during a write. Expect all outputs 0 on the next edge.
